// File: rtl/prbs_checker_if.sv
// Bus bundle for prbs_checker: serial input, counter clear, and status outputs.
// Handshake: en is a valid qualifier with no back-pressure. The checker
// accepts din on every clk edge where en==1, and ignores din otherwise.
// dbg_state exposes the checker FSM state (0=FILL, 1=SYNC, 2=LOCKED).
interface prbs_checker_if;
  logic        en;
  logic        din;
  logic        clr_count;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  modport master (
    output en, din, clr_count,
    input  locked, err, err_count, dbg_state
  );

  modport slave (
    input  en, din, clr_count,
    output locked, err, err_count, dbg_state
  );
endinterface

// File: rtl/prbs_checker.sv
// Receive-side checker for the 4-tap PRBS stream.
// The checker fills its history, then looks for LOCK_COUNT consecutive bits
// that obey the recurrence. Once locked, it counts bit errors, and it drops
// lock if too many errors fall inside one WINDOW of valid bits.
// Optional macro PRBS_FREERUN_EN: while LOCKED, the history shifts in the
// predicted bit rather than the received bit. The reference then free-runs,
// so one flipped input bit counts as exactly one error.
module prbs_checker #(
  parameter int WIDTH      = 32,
  parameter int TAP_0      = 31,
  parameter int TAP_1      = 27,
  parameter int TAP_2      = 8,
  parameter int TAP_3      = 6,
  parameter int LOCK_COUNT = 32,
  parameter int WINDOW     = 1024,
  parameter int LOSS_ERRS  = 8
) (
  input  logic          clk,
  input  logic          rst,
  prbs_checker_if.slave bus
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WBITS_W = $clog2(WINDOW);
  localparam int WERRS_W = $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [WBITS_W-1:0] win_bits_q, win_bits_d;
  logic [WERRS_W-1:0] win_errs_q, win_errs_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [15:0]        err_count_q, err_count_d;

  logic expected;
  logic mismatch;
  logic shift_bit;

  // Next-state logic: prediction, FSM transitions, counters and history shift.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    err_count_d = err_count_q;
    err_d       = 1'b0;

    expected  = hist_q[TAP_0] ^ hist_q[TAP_1] ^ hist_q[TAP_2] ^ hist_q[TAP_3];
    mismatch  = bus.din ^ expected;
    shift_bit = bus.din;

    if (bus.en) begin
      case (state_q)
        ST_FILL: begin
          // No comparisons here: the history is not yet meaningful.
          if (fill_cnt_q == FILL_W'(WIDTH - 1)) begin
            state_d     = ST_SYNC;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end
        end

        ST_SYNC: begin
          // An all-zero history trivially satisfies the recurrence, so it
          // must never count towards lock.
          if ((hist_q == '0) || mismatch) begin
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
          end
          if (match_cnt_d == MATCH_W'(LOCK_COUNT)) begin
            state_d    = ST_LOCKED;
            win_bits_d = '0;
            win_errs_d = '0;
          end
        end

        ST_LOCKED: begin
`ifdef PRBS_FREERUN_EN
          shift_bit = expected;
`endif
          if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
            win_errs_d = win_errs_q + WERRS_W'(1);
          end
          // The wrap bit opens a fresh window and its own error counts in it.
          if (win_bits_q == WBITS_W'(WINDOW - 1)) begin
            win_bits_d = '0;
            win_errs_d = mismatch ? WERRS_W'(1) : '0;
          end else begin
            win_bits_d = win_bits_q + WBITS_W'(1);
          end
          if (win_errs_d == WERRS_W'(LOSS_ERRS)) begin
            state_d     = ST_SYNC;
            match_cnt_d = '0;
          end
        end

        default: begin
          state_d = ST_FILL;
        end
      endcase

      hist_d = {hist_q[WIDTH-2:0], shift_bit};
    end

    // The clear is a control input rather than stream data, so it acts
    // whether or not a bit is valid, and it overrides a coincident error.
    if (bus.clr_count) begin
      err_count_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: bit-queue reference model plus
// directed scenarios. Honours PRBS_FREERUN_EN for the mode-dependent numbers.
module tb_prbs_checker;

  localparam int WIDTH      = 32;
  localparam int LOCK_COUNT = 32;
  localparam int WINDOW     = 1024;
  localparam int LOSS_ERRS  = 8;

`ifdef PRBS_FREERUN_EN
  localparam int SINGLE_ERRS = 1;
  localparam int RELOCK_MAX  = 32;
`else
  localparam int SINGLE_ERRS = 5;
  localparam int RELOCK_MAX  = 64;
`endif

  logic clk = 1'b0;
  logic rst;

  // Clock and reset
  always #5 clk = ~clk;

  prbs_checker_if bus ();

  prbs_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference generator, same taps as the link-side LFSR.
  logic [31:0] gen_q;
  task automatic gen_bit(output logic b);
    b = gen_q[31] ^ gen_q[27] ^ gen_q[8] ^ gen_q[6];
    gen_q = {gen_q[30:0], b};
  endtask

  // Model: queue of bits shifted into the history, plus counts since reset/lock.
  logic m_bits[$];
  int   m_valid;
  bit   m_locked;
  int   m_run;
  int   m_lpos;
  int   m_werrs;
  int   m_cnt;
  bit   m_err;

  function automatic logic tap(input int k);
    if (m_bits.size() > k) return m_bits[m_bits.size() - 1 - k];
    return 1'b0;
  endfunction

  function automatic bit hist_zero();
    for (int k = 0; k < WIDTH; k++) if (tap(k) != 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic d, input logic c);
    logic ex, mm, sb;
    if (!r) begin
      m_bits.delete();
      m_valid = 0; m_locked = 0; m_run = 0; m_lpos = 0;
      m_werrs = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (e) begin
        ex = tap(31) ^ tap(27) ^ tap(8) ^ tap(6);
        mm = d ^ ex;
        sb = d;
        if (m_valid < WIDTH) begin
          m_valid++;
        end else if (!m_locked) begin
          if (hist_zero() || mm) m_run = 0;
          else m_run++;
          if (m_run == LOCK_COUNT) begin
            m_locked = 1; m_lpos = 0; m_werrs = 0;
          end
        end else begin
`ifdef PRBS_FREERUN_EN
          sb = ex;
`endif
          if (mm) begin
            m_err = 1;
            if (m_cnt < 65535) m_cnt++;
          end
          if ((m_lpos % WINDOW) == WINDOW - 1) m_werrs = int'(mm);
          else m_werrs += int'(mm);
          m_lpos++;
          if (m_werrs >= LOSS_ERRS) begin
            m_locked = 0; m_run = 0;
          end
        end
        m_bits.push_back(sb);
        if (m_bits.size() > WIDTH) void'(m_bits.pop_front());
      end
      if (c) m_cnt = 0;
    end
    exp_q.push_back({m_locked, m_err, m_cnt[15:0]});
  endtask

  // Driver: one clock cycle of stimulus; returns just after the sampling edge.
  task automatic cycle(input logic r, input logic e, input logic d, input logic c);
    @(negedge clk);
    rst = r; bus.en = e; bus.din = d; bus.clr_count = c;
    model_step(r, e, d, c);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compare every cycle's registered outputs with the model.
  initial begin
    logic [17:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("locked", {31'd0, bus.locked}, {31'd0, exp[17]});
        check("err", {31'd0, bus.err}, {31'd0, exp[16]});
        check("err_count", {16'd0, bus.err_count}, {16'd0, exp[15:0]});
      end
    end
  end

  // Directed scenarios
  initial begin
    logic b;
    int lock_at, pulses, relock, valid, errs;
    bit fell, ever_locked;
    logic [15:0] cnt_snap;

    rst = 1'b0; bus.en = 1'b0; bus.din = 1'b0; bus.clr_count = 1'b0;
    gen_q = 32'h0000_0001;

    // Reset state
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("reset_locked", {31'd0, bus.locked}, 32'd0);
    check("reset_count", {16'd0, bus.err_count}, 32'd0);

    // Lock acquisition on a clean stream
    lock_at = 0;
    for (int i = 1; i <= 80; i++) begin
      gen_bit(b);
      cycle(1, 1, b, 0);
      if (bus.locked && lock_at == 0) lock_at = i;
    end
    check("lock_point", lock_at, 32'd64);
    check("lock_count", {16'd0, bus.err_count}, 32'd0);

    // Single flipped bit
    for (int i = 0; i < 10; i++) begin gen_bit(b); cycle(1, 1, b, 0); end
    pulses = 0;
    gen_bit(b);
    cycle(1, 1, ~b, 0);
    pulses += int'(bus.err);
    for (int i = 0; i < 60; i++) begin
      gen_bit(b);
      cycle(1, 1, b, 0);
      pulses += int'(bus.err);
    end
    check("single_err_count", {16'd0, bus.err_count}, SINGLE_ERRS);
    check("single_err_pulses", pulses, SINGLE_ERRS);
    check("single_err_locked", {31'd0, bus.locked}, 32'd1);

    // Run past a window boundary so earlier errors leave the window
    for (int i = 0; i < 1100; i++) begin gen_bit(b); cycle(1, 1, b, 0); end
    check("window_locked", {31'd0, bus.locked}, 32'd1);

    // Clear coincident with an error
    gen_bit(b);
    cycle(1, 1, ~b, 1);
    check("clr_wins", {16'd0, bus.err_count}, 32'd0);
    for (int i = 0; i < 40; i++) begin gen_bit(b); cycle(1, 1, b, 0); end
    check("clr_locked", {31'd0, bus.locked}, 32'd1);

    // Reset while locked, then relock
    cycle(0, 1, 0, 0);
    check("midreset_locked", {31'd0, bus.locked}, 32'd0);
    check("midreset_count", {16'd0, bus.err_count}, 32'd0);
    lock_at = 0;
    for (int i = 1; i <= 80; i++) begin
      gen_bit(b);
      cycle(1, 1, b, 0);
      if (bus.locked && lock_at == 0) lock_at = i;
    end
    check("relock_point_after_reset", lock_at, 32'd64);

    // Loss of lock: 8 consecutive flipped bits, then clean bits
    fell = 0;
    for (int i = 0; i < 8; i++) begin
      gen_bit(b);
      cycle(1, 1, ~b, 0);
      if (!bus.locked) fell = 1;
    end
    relock = 0;
    cnt_snap = 16'd0;
    for (int k = 1; k <= 100; k++) begin
      gen_bit(b);
      cycle(1, 1, b, 0);
      if (!bus.locked && !fell) fell = 1;
      if (!bus.locked) cnt_snap = bus.err_count;
      if (fell && bus.locked && relock == 0) relock = k;
    end
    check("loss_fell", {31'd0, fell}, 32'd1);
    check("loss_count_ge8", {31'd0, (cnt_snap >= 16'd8)}, 32'd1);
    check("relock_within", {31'd0, (relock > 0 && relock <= RELOCK_MAX)}, 32'd1);
    check("relock_point", relock, RELOCK_MAX);

    // All-zero stream never locks
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    ever_locked = 0; errs = 0;
    for (int i = 0; i < 500; i++) begin
      cycle(1, 1, 0, 0);
      if (bus.locked) ever_locked = 1;
      errs += int'(bus.err);
    end
    check("zero_never_locked", {31'd0, ever_locked}, 32'd0);
    check("zero_no_err", errs, 32'd0);
    check("zero_count", {16'd0, bus.err_count}, 32'd0);

    // en gaps with junk on din while invalid
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    gen_q = 32'h0000_0001;
    valid = 0; lock_at = 0; errs = 0;
    for (int i = 0; i < 400 && valid < 80; i++) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      if (e) begin
        gen_bit(b);
        valid++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      cycle(1, e, b, 0);
      if (bus.locked && lock_at == 0) lock_at = valid;
      errs += int'(bus.err);
    end
    check("gaps_lock_point", lock_at, 32'd64);
    check("gaps_no_err", errs, 32'd0);
    check("gaps_count", {16'd0, bus.err_count}, 32'd0);

    cycle(1, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
